// File: rtl/upcntr_seq_ctrl.sv
// upcntr_seq_ctrl: issues prescaled trigger pulses to a 2-bit up-counter and mirrors its value.
// Optional wrap indication built only when UPCNTR_SEQ_WRAP_IRQ_EN is defined.
module upcntr_seq_ctrl #(
   parameter int PRESCALE_W = 8,
   parameter int STEPS_W    = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  stop,
   input  logic [PRESCALE_W-1:0] prescale,
   input  logic [STEPS_W-1:0]    steps,
   output logic                  trigger,
   output logic                  busy,
   output logic                  done,
   output logic [STEPS_W-1:0]    steps_left,
   output logic [1:0]            cnt_mirror,
   output logic                  wrap_pulse
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]            state;
   logic [PRESCALE_W-1:0] pre_cnt;
   logic [PRESCALE_W-1:0] pre_lat;

   assign busy    = state == RUN;
   assign done    = state == DONE;
   // stop suppresses a coincident trigger so the counter never sees an aborted step
   assign trigger = busy && pre_cnt == '0 && !stop;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         pre_cnt    <= '0;
         pre_lat    <= '0;
         steps_left <= '0;
         cnt_mirror <= 2'd0;
      end else if (state == IDLE && start) begin
         pre_cnt    <= prescale;
         pre_lat    <= prescale;
         steps_left <= steps;
         state      <= steps != '0 ? RUN : DONE;
      end else if (busy) begin
         if (stop)
            state <= IDLE;
         else if (pre_cnt != '0)
            pre_cnt <= pre_cnt - 1'b1;
         else begin
            steps_left <= steps_left - 1'b1;
            cnt_mirror <= cnt_mirror + 2'd1;
            if (steps_left == STEPS_W'(1))
               state <= DONE;
            else
               pre_cnt <= pre_lat;
         end
      end else if (state != IDLE)
         state <= IDLE;
   end

`ifdef UPCNTR_SEQ_WRAP_IRQ_EN
   assign wrap_pulse = trigger && cnt_mirror == 2'd3;
`else
   assign wrap_pulse = 1'b0;
`endif
endmodule

// File: tb/tb_upcntr_seq_ctrl.sv
// tb_upcntr_seq_ctrl: randomized sequences checked against an arithmetic timing model.
module tb_upcntr_seq_ctrl;
   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic [7:0] prescale = '0;
   logic [7:0] steps = '0;
   logic       trigger, busy, done, wrap_pulse;
   logic [7:0] steps_left;
   logic [1:0] cnt_mirror;
   int         n_chk = 0;
   int         n_pass = 0;
   int         m = 0;

   upcntr_seq_ctrl #(.PRESCALE_W(8), .STEPS_W(8)) dut (
      .clk(clk), .reset(reset), .start(start), .stop(stop),
      .prescale(prescale), .steps(steps), .trigger(trigger), .busy(busy),
      .done(done), .steps_left(steps_left), .cnt_mirror(cnt_mirror),
      .wrap_pulse(wrap_pulse)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
   endtask

   task automatic check_idle_zero(input string tag);
      check({tag, " trigger"}, int'(trigger), 0);
      check({tag, " busy"}, int'(busy), 0);
      check({tag, " done"}, int'(done), 0);
      check({tag, " wrap"}, int'(wrap_pulse), 0);
      check({tag, " steps_left"}, int'(steps_left), 0);
      check({tag, " cnt_mirror"}, int'(cnt_mirror), 0);
   endtask

   // t counts cycles from the edge that accepts start; trigger k falls at k*(p+1)+p
   task automatic run_seq(input int p, input int s, input int c);
      int  per, last, bsy, trig, wrp, issued;
      bit  stopped;
      per     = p + 1;
      stopped = c >= 0 && s != 0 && c < s * per;
      last    = s == 0 ? 0 : stopped ? c : s * per;
      @(posedge clk); #1;
      start = 1'b1; prescale = 8'(p); steps = 8'(s); stop = 1'b0;
      for (int t = 0; t <= last + 2; t++) begin
         @(posedge clk); #1;
         start    = t <= last ? 1'($urandom_range(0, 1)) : 1'b0;
         prescale = 8'($urandom);
         steps    = 8'($urandom);
         stop     = (stopped && t == c) ? 1'b1 : t > last ? 1'($urandom_range(0, 1)) : 1'b0;
         bsy      = (s != 0 && t < (stopped ? c + 1 : s * per)) ? 1 : 0;
         trig     = (bsy == 1 && t % per == p && !(stopped && t == c)) ? 1 : 0;
         wrp      = 0;
`ifdef UPCNTR_SEQ_WRAP_IRQ_EN
         wrp      = (trig == 1 && m == 3) ? 1 : 0;
`endif
         issued = 0;
         for (int k = 0; k < s; k++)
            if (k * per + p < t && !(stopped && k * per + p >= c)) issued++;
         @(negedge clk);
         check("trigger", int'(trigger), trig);
         check("busy", int'(busy), bsy);
         check("done", int'(done), (!stopped && t == last) ? 1 : 0);
         check("wrap_pulse", int'(wrap_pulse), wrp);
         check("cnt_mirror", int'(cnt_mirror), m);
         if (s != 0) check("steps_left", int'(steps_left), s - issued);
         m = (m + trig) % 4;
      end
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 check_idle_zero("in_reset");
      @(negedge clk) reset = 1'b1;
      @(negedge clk) check_idle_zero("after_reset");
      run_seq(2, 3, -1);
      run_seq(0, 5, -1);
      run_seq(3, 4, 7);
      run_seq(0, 0, -1);
      run_seq(1, 2, -1);
      for (int i = 0; i < 30; i++) begin
         int p, s, c;
         p = $urandom_range(0, 4);
         s = $urandom_range(0, 6);
         c = $urandom_range(0, 3) == 0 ? $urandom_range(0, s * (p + 1)) : -1;
         run_seq(p, s, c);
      end
      @(posedge clk); #1;
      start = 1'b1; prescale = 8'd1; steps = 8'd4; stop = 1'b0;
      @(posedge clk); #1 start = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      #1 check_idle_zero("mid_run_reset");
      m = 0;
      @(negedge clk) reset = 1'b1;
      run_seq(0, 3, -1);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/upcntr_seq_ctrl.md
Name: upcntr_seq_ctrl

Overview:
Sequencer that drives the trigger input of the 2-bit up-counter and mirrors its value.
- On a start command it issues a programmed number of single-cycle trigger pulses, spaced by a programmable prescale interval.
- It then reports completion.
- It sits between the control/config logic and the counter, sharing the counter's clk and reset.

Parameters:
PRESCALE_W, 8, width of the prescale interval field
STEPS_W, 8, width of the step-count field

Ports:
clk  input  1  system clock, all flops rising-edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
start  input  1  request to begin a sequence; sampled only in IDLE
stop  input  1  abort request; sampled in RUN
prescale  input  PRESCALE_W  idle cycles between triggers; latched on accepted start
steps  input  STEPS_W  number of triggers to issue; latched on accepted start
trigger  output  1  one-cycle advance pulse to the counter's trigger input
busy  output  1  high while in RUN
done  output  1  one-cycle pulse on normal completion
steps_left  output  STEPS_W  remaining triggers in the current sequence
cnt_mirror  output  2  local copy of the counter value, modulo 4
wrap_pulse  output  1  counter-wrap indication (see Optional Feature)

Behaviour:
- States: IDLE, RUN, DONE.
- Reset (reset=0, asynchronous):
  - state=IDLE; pre_cnt=0; steps_left=0; cnt_mirror=0.
  - trigger=0, busy=0, done=0, wrap_pulse=0.
  - Release is synchronous to the next clk edge.
- IDLE:
  - start=1 with steps!=0 at edge E0 → RUN.
    - pre_cnt loads prescale; steps_left loads steps.
  - start=1 with steps==0 → DONE directly. No trigger is issued.
  - stop is ignored in IDLE.
- RUN:
  - busy=1.
  - trigger is a decode of registered state: trigger = (state==RUN && pre_cnt==0 && stop==0).
  - pre_cnt!=0 → decrement pre_cnt each cycle.
  - pre_cnt==0 and stop==0 (trigger cycle):
    - trigger=1; steps_left decrements by 1; cnt_mirror increments modulo 4 (3→0).
    - If steps_left was 1 → DONE; otherwise pre_cnt reloads the latched prescale.
  - stop=1 on any RUN cycle → IDLE next edge; no done pulse.
    - Stop wins over a coincident trigger cycle; no trigger is issued that cycle.
    - steps_left holds its value, so software can read how many triggers were not issued.
- DONE: done=1 for exactly one cycle; busy=0; → IDLE next edge. start is ignored in DONE.
- Timing:
  - First trigger is high in the cycle starting at edge E0+prescale, i.e. prescale+1 cycles after start is sampled.
  - Trigger period is prescale+1 cycles; prescale=0 gives back-to-back triggers.
  - done is high one cycle after the last trigger.
- Latched prescale/steps are immune to input changes while busy.
- start while busy/DONE is dropped (not queued).
- Reset asserted mid-sequence: everything returns to reset values immediately. No partial trigger pulse.
- cnt_mirror tracks the counter exactly because both share reset and only this block drives trigger. It is not reset by start.

Optional Feature:
Macro UPCNTR_SEQ_WRAP_IRQ_EN.
- Defined: wrap_pulse=1 in the same cycle as a trigger while cnt_mirror==3, i.e. the counter wraps 3→0 at the next edge.
- Undefined: wrap_pulse is tied to 0 and the wrap-detect logic is not built.
- No other behaviour changes.

Test Plan:
1. Reset held low 3 cycles, then released → all outputs 0, state IDLE; assert reset mid-RUN → busy/trigger drop to 0 immediately, cnt_mirror=0.
2. prescale=2, steps=3, start pulse → triggers 3, 6, 9 cycles after start is sampled; done pulse 10 cycles after start is sampled; steps_left 3→2→1→0; cnt_mirror 0→1→2→3.
3. prescale=0, steps=5 → 5 consecutive trigger cycles, done next cycle, cnt_mirror ends at 1 (wrapped); with UPCNTR_SEQ_WRAP_IRQ_EN, wrap_pulse high only on the 4th trigger.
4. prescale=3, steps=4, stop asserted on the 2nd trigger cycle → exactly 1 trigger issued, no done, busy low next cycle, steps_left=3.
5. steps=0 with start → no trigger, done pulse 1 cycle after start is sampled, busy never high.
6. start re-pulsed and prescale/steps changed while busy (prescale=1, steps=2 running) → ignored; exactly 2 triggers 2 cycles apart, one done.
